// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
// Holds the FSM state encoding, default sizing and the golden truth-table
// mask of the evaluator F = A(CD+B) + BC' over {A,B,C,D}.
package truth_table_scanner_pkg;

  localparam int unsigned N_IN_DEF          = 4;
  localparam int unsigned SETTLE_CYCLES_DEF = 1;

  // Minterms 4,5,11,12,13,14,15 of the current evaluator function.
  localparam logic [15:0] F_MASK_REF = 16'hF830;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Control/result bundle between a scan controller and the scanner.
//   start, abort : scan control levels, sampled at clk
//   f_in         : evaluator output returned to the scanner
//   vec_out      : vector driven to the evaluator (MSB = A, LSB = D)
//   busy, done   : scan in progress / one-cycle completion pulse
//   truth_table  : captured F per vector, ones_count : number of 1s captured
interface truth_table_scanner_if
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF
) ();

  logic                 start;
  logic                 abort;
  logic                 f_in;
  logic [N_IN-1:0]      vec_out;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   truth_table;
  logic [N_IN:0]        ones_count;

  // master drives stimulus/control and reads results
  modport master (
    output start, abort, f_in,
    input  vec_out, busy, done, truth_table, ones_count
  );

  // slave is the scanner itself
  modport slave (
    input  start, abort, f_in,
    output vec_out, busy, done, truth_table, ones_count
  );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable down-counter timing how long each vector is held.
//   clk, rst_n : clock and async active-low reset
//   load       : load load_val this edge (has priority over counting)
//   load_val   : value to load
//   zero_c     : counter is at zero (combinational decode of the flop)
module truth_table_scanner_settle_timer #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero_c
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counts down to zero and parks there until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input vector of a combinational evaluator, holds each for
// SETTLE_CYCLES clocks, samples F and builds a truth-table mask and ones count.
//   clk, rst_n : clock and async active-low reset
//   bus        : slave side of truth_table_scanner_if (start/abort/f_in in,
//                vec_out/busy/done/truth_table/ones_count out, all registered)
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned N_IN          = N_IN_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_scanner_if.slave   bus
);

  localparam int unsigned N_VEC = 2**N_IN;
  localparam int unsigned CW    = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned OW    = N_IN + 1;

  localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              done_q, done_d;
  logic [N_VEC-1:0]  tt_q, tt_d;
  logic [OW-1:0]     ones_q, ones_d;

  logic              ld;
  logic [CW-1:0]     ld_val;
  logic              zero_c;

  truth_table_scanner_settle_timer #(
    .CW (CW)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .zero_c   (zero_c)
  );

  // Next-state and result update.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    ones_d  = ones_q;
    ld      = 1'b0;
    ld_val  = RELOAD;

    case (state_q)
      ST_IDLE: begin
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          state_d = ST_SCAN;
          vec_d   = '0;
          tt_d    = '0;
          ones_d  = '0;
          ld      = 1'b1;
        end
      end
      ST_SCAN: begin
        if (bus.abort) begin
          // Partial results stay; timer parked at zero for the next scan.
          state_d = ST_IDLE;
          vec_d   = '0;
          ld      = 1'b1;
          ld_val  = '0;
        end else if (zero_c) begin
          tt_d[vec_q] = bus.f_in;
          ones_d      = ones_q + OW'(bus.f_in);
          if (vec_q == VEC_LAST) begin
            // Terminal vector exits before incrementing, so vec_out never wraps.
            state_d = ST_IDLE;
            vec_d   = '0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + N_IN'(1);
            ld    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.vec_out     = vec_q;
  assign bus.busy        = (state_q == ST_SCAN);
  assign bus.done        = done_q;
  assign bus.truth_table = tt_q;
  assign bus.ones_count  = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: one instance with a single
// settle cycle and one with three, each fed by a golden evaluator model.
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  typedef struct {
    logic [15:0] mask;
    logic [4:0]  ones;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   mode1        = 0;     // 0 golden, 1 tie high, 2 tie low
  logic glitch3      = 1'b0;  // inverts f_in of the 3-cycle instance
  exp_t exp_q[$];

  always #5 clk = ~clk;

  truth_table_scanner_if #(.N_IN(4)) if1 ();
  truth_table_scanner_if #(.N_IN(4)) if3 ();

  truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  // Golden evaluator: F = A(CD+B) + BC', v = {A,B,C,D}
  function automatic logic eval_f(input logic [3:0] v);
    return (v[3] & ((v[1] & v[0]) | v[2])) | (v[2] & ~v[1]);
  endfunction

  function automatic logic [15:0] model_mask(input int n);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = eval_f(4'(i));
    return m;
  endfunction

  function automatic logic [4:0] model_ones(input int n);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < n; i++) c = c + 5'(eval_f(4'(i)));
    return c;
  endfunction

  always_comb begin
    case (mode1)
      1:       if1.f_in = 1'b1;
      2:       if1.f_in = 1'b0;
      default: if1.f_in = eval_f(if1.vec_out);
    endcase
    if3.f_in = eval_f(if3.vec_out) ^ glitch3;
  end

  // Drive a one-cycle start on the 1-cycle instance; returns just after edge k.
  task automatic pulse_start1();
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
  endtask

  // Wait (bounded) for done on the 1-cycle instance; lat = edges after edge k.
  task automatic wait_done1(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1) begin
        seen = 1'b1;
        lat  = c;
      end
    end
  endtask

  task automatic test_reset();
    if1.start = 1'b0; if1.abort = 1'b0;
    if3.start = 1'b0; if3.abort = 1'b0;
    rst_n = 1'b0;
    #12;
    tests_run++;
    if ({if1.vec_out, if1.busy, if1.done, if1.truth_table, if1.ones_count} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_s1: got vec=%h busy=%b done=%b tt=%h ones=%0d, want all 0",
               if1.vec_out, if1.busy, if1.done, if1.truth_table, if1.ones_count);
    end
    tests_run++;
    if ({if3.vec_out, if3.busy, if3.done, if3.truth_table, if3.ones_count} !== 27'd0) begin
      tests_failed++;
      $display("FAIL reset_s3: got vec=%h busy=%b done=%b tt=%h ones=%0d, want all 0",
               if3.vec_out, if3.busy, if3.done, if3.truth_table, if3.ones_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden();
    exp_t e;
    int   lat;
    bit   seen;
    mode1 = 0;
    pulse_start1();
    tests_run++;
    if (if1.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL golden_busy_rise: got %b want 1", if1.busy);
    end
    e.mask = model_mask(16); e.ones = model_ones(16); e.lat = 16;
    exp_q.push_back(e);
    wait_done1(lat, seen);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || lat != e.lat) begin
      tests_failed++;
      $display("FAIL golden_done_latency: got seen=%b lat=%0d want lat=%0d", seen, lat, e.lat);
    end
    tests_run++;
    if (if1.truth_table !== e.mask || if1.ones_count !== e.ones) begin
      tests_failed++;
      $display("FAIL golden_result: got tt=%h ones=%0d want tt=%h ones=%0d",
               if1.truth_table, if1.ones_count, e.mask, e.ones);
    end
    tests_run++;
    if (if1.truth_table !== F_MASK_REF) begin
      tests_failed++;
      $display("FAIL golden_ref_mask: got %h want %h", if1.truth_table, F_MASK_REF);
    end
    @(negedge clk);
    tests_run++;
    if ({if1.done, if1.busy, if1.vec_out} !== 6'd0) begin
      tests_failed++;
      $display("FAIL golden_done_width: got done=%b busy=%b vec=%h want 0/0/0",
               if1.done, if1.busy, if1.vec_out);
    end
  endtask

  task automatic test_tie();
    exp_t e;
    int   lat;
    bit   seen;
    for (int m = 1; m <= 2; m++) begin
      mode1 = m;
      pulse_start1();
      e.mask = (m == 1) ? 16'hFFFF : 16'h0000;
      e.ones = (m == 1) ? 5'd16 : 5'd0;
      e.lat  = 16;
      exp_q.push_back(e);
      wait_done1(lat, seen);
      e = exp_q.pop_front();
      tests_run++;
      if (!seen || lat != e.lat) begin
        tests_failed++;
        $display("FAIL tie%0d_done: got seen=%b lat=%0d want lat=%0d", m, seen, lat, e.lat);
      end
      tests_run++;
      if (if1.truth_table !== e.mask || if1.ones_count !== e.ones) begin
        tests_failed++;
        $display("FAIL tie%0d_result: got tt=%h ones=%0d want tt=%h ones=%0d",
                 m, if1.truth_table, if1.ones_count, e.mask, e.ones);
      end
      @(negedge clk);
    end
    mode1 = 0;
  endtask

  task automatic test_settle3();
    exp_t e;
    int   lat;
    bit   seen;
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    // now just after edge k; next edge k+1 is not a sample edge
    glitch3 = 1'b1;
    e.mask = model_mask(16); e.ones = model_ones(16); e.lat = 48;
    exp_q.push_back(e);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      if (if3.done === 1'b1) begin
        seen = 1'b1;
        lat  = c;
      end else if (c < 48) begin
        tests_run++;
        if (if3.vec_out !== 4'(c / 3)) begin
          tests_failed++;
          $display("FAIL s3_vec_step@%0d: got %0d want %0d", c, if3.vec_out, c / 3);
        end
      end
      // corrupt f_in only around edges that are not sample edges
      glitch3 = ((c + 1) % 3 != 0) && (c + 1 < 48);
    end
    glitch3 = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || lat != e.lat) begin
      tests_failed++;
      $display("FAIL s3_done_latency: got seen=%b lat=%0d want lat=%0d", seen, lat, e.lat);
    end
    tests_run++;
    if (if3.truth_table !== e.mask || if3.ones_count !== e.ones) begin
      tests_failed++;
      $display("FAIL s3_result: got tt=%h ones=%0d want tt=%h ones=%0d",
               if3.truth_table, if3.ones_count, e.mask, e.ones);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int dones;
    mode1 = 0;
    pulse_start1();
    // vectors 0..5 sampled at edges k+1..k+6, abort lands on edge k+7
    for (int j = 1; j <= 6; j++) @(negedge clk);
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    tests_run++;
    if ({if1.busy, if1.done, if1.vec_out} !== 6'd0) begin
      tests_failed++;
      $display("FAIL abort_state: got busy=%b done=%b vec=%h want 0/0/0",
               if1.busy, if1.done, if1.vec_out);
    end
    tests_run++;
    if (if1.truth_table !== model_mask(6) || if1.ones_count !== model_ones(6)) begin
      tests_failed++;
      $display("FAIL abort_partial: got tt=%h ones=%0d want tt=%h ones=%0d",
               if1.truth_table, if1.ones_count, model_mask(6), model_ones(6));
    end
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      if (if1.done === 1'b1 || if1.busy === 1'b1) dones++;
      @(negedge clk);
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d busy/done cycles want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   seen;
    mode1 = 0;
    pulse_start1();
    e.mask = model_mask(16); e.ones = model_ones(16); e.lat = 16;
    exp_q.push_back(e);
    seen = 1'b0;
    lat  = 0;
    for (int j = 1; j <= 200 && !seen; j++) begin
      if1.start = (j == 4);   // restart attempt mid-scan
      @(negedge clk);
      if (if1.done === 1'b1) begin
        seen = 1'b1;
        lat  = j;
      end
    end
    if1.start = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || lat != e.lat || if1.truth_table !== e.mask || if1.ones_count !== e.ones) begin
      tests_failed++;
      $display("FAIL restart_ignored: got seen=%b lat=%0d tt=%h ones=%0d want lat=%0d tt=%h ones=%0d",
               seen, lat, if1.truth_table, if1.ones_count, e.lat, e.mask, e.ones);
    end
    // start during the done cycle
    pulse_start1();
    tests_run++;
    if (if1.busy !== 1'b1 || if1.truth_table !== 16'h0000 || if1.ones_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL start_in_done: got busy=%b tt=%h ones=%0d want 1/0000/0",
               if1.busy, if1.truth_table, if1.ones_count);
    end
    e.mask = model_mask(16); e.ones = model_ones(16); e.lat = 16;
    exp_q.push_back(e);
    wait_done1(lat, seen);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || lat != e.lat || if1.truth_table !== e.mask || if1.ones_count !== e.ones) begin
      tests_failed++;
      $display("FAIL second_scan: got seen=%b lat=%0d tt=%h ones=%0d want lat=%0d tt=%h ones=%0d",
               seen, lat, if1.truth_table, if1.ones_count, e.lat, e.mask, e.ones);
    end
    @(negedge clk);
    // start and abort together in idle
    if1.start = 1'b1;
    if1.abort = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if1.abort = 1'b0;
    tests_run++;
    if (if1.busy !== 1'b0 || if1.truth_table !== model_mask(16)) begin
      tests_failed++;
      $display("FAIL start_abort_idle: got busy=%b tt=%h want 0/%h",
               if1.busy, if1.truth_table, model_mask(16));
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   lat;
    bit   seen;
    mode1 = 0;
    pulse_start1();
    for (int j = 0; j < 5; j++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({if1.vec_out, if1.busy, if1.done, if1.truth_table, if1.ones_count} !== 27'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got vec=%h busy=%b done=%b tt=%h ones=%0d want all 0",
               if1.vec_out, if1.busy, if1.done, if1.truth_table, if1.ones_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start1();
    e.mask = model_mask(16); e.ones = model_ones(16); e.lat = 16;
    exp_q.push_back(e);
    wait_done1(lat, seen);
    e = exp_q.pop_front();
    tests_run++;
    if (!seen || lat != e.lat || if1.truth_table !== e.mask || if1.ones_count !== e.ones) begin
      tests_failed++;
      $display("FAIL post_reset_scan: got seen=%b lat=%0d tt=%h ones=%0d want lat=%0d tt=%h ones=%0d",
               seen, lat, if1.truth_table, if1.ones_count, e.lat, e.mask, e.ones);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_tie();
    test_settle3();
    test_abort();
    test_back_to_back();
    test_async_reset();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
